// File: rtl/scan_reg_pkg.sv
// Shared types and helpers for the scannable register bank: mode encoding,
// chain-length computation and parameter legality check.
package scan_reg_pkg;

  typedef enum logic [1:0] {
    MODE_HOLD  = 2'b00,
    MODE_LOAD  = 2'b01,
    MODE_SHIFT = 2'b10
  } scan_mode_t;

  function automatic int chain_len(input int width, input int chains);
    return width / chains;
  endfunction

  function automatic bit params_ok(input int width, input int chains);
    return (chains > 0) && ((width % chains) == 0) && ((width / chains) >= 2);
  endfunction

endpackage

// File: rtl/scan_reg_chain.sv
// One L-bit muxed-scan chain. Shifting moves data toward bit L-1, which is
// the chain's scan-out.
module scan_reg_chain
  import scan_reg_pkg::*;
#(
  parameter int           L       = 8,
  parameter logic [L-1:0] RST_VAL = {L{1'b0}}
) (
  input  logic         CLK,
  input  logic         R,
  input  scan_mode_t   mode,
  input  logic         si,
  input  logic [L-1:0] d,
  output logic [L-1:0] q
);

  logic [L-1:0] q_r;

  // chain state: shift, functional load or hold; an unknown mode poisons the chain
  always_ff @(posedge CLK or posedge R) begin
    if (R) begin
      q_r <= RST_VAL;
    end else begin
      case (mode)
        MODE_SHIFT: q_r <= {q_r[L-2:0], si};
        MODE_LOAD:  q_r <= d;
        MODE_HOLD:  q_r <= q_r;
        default:    q_r <= {L{1'bx}};
      endcase
    end
  end

  assign q = q_r;

endmodule

// File: rtl/scan_reg_bank.sv
// Scannable register vector split into CHAINS equal chains, with a shift-run
// counter that flags a complete chain load and a pulse on functional capture.
module scan_reg_bank
  import scan_reg_pkg::*;
#(
  parameter int               WIDTH     = 16,
  parameter int               CHAINS    = 2,
  parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}}
) (
  input  logic              CLK,
  input  logic              R,
  input  logic              SE,
  input  logic              E,
  input  logic [WIDTH-1:0]  D,
  input  logic [CHAINS-1:0] SI,
  output logic [WIDTH-1:0]  Q,
  output logic [CHAINS-1:0] SO,
  output logic              SHIFT_DONE,
  output logic              CAPTURED
);

  localparam int L     = chain_len(WIDTH, CHAINS);
  localparam int CNT_W = (L > 1) ? $clog2(L) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(L - 1);

  if (!params_ok(WIDTH, CHAINS)) begin : g_bad_params
    $error("scan_reg_bank: WIDTH must be a multiple of CHAINS with chain length >= 2");
  end

  scan_mode_t       mode_s;
  logic [CNT_W-1:0] cnt_r;
  logic             shift_done_r;
  logic             captured_r;

  // mode decode; the ternary form lets an unknown SE propagate as an unknown mode
  always_comb begin
    mode_s = MODE_HOLD;
    mode_s = SE ? MODE_SHIFT : (E ? MODE_LOAD : MODE_HOLD);
  end

  for (genvar c = 0; c < CHAINS; c++) begin : g_chain
    scan_reg_chain #(
      .L       (L),
      .RST_VAL (RESET_VAL[c*L +: L])
    ) u_chain (
      .CLK  (CLK),
      .R    (R),
      .mode (mode_s),
      .si   (SI[c]),
      .d    (D[c*L +: L]),
      .q    (Q[c*L +: L])
    );
    assign SO[c] = Q[c*L + L - 1];
  end

  // shift-run counter and the two status pulses; any non-shift cycle restarts the run
  always_ff @(posedge CLK or posedge R) begin
    if (R) begin
      cnt_r        <= {CNT_W{1'b0}};
      shift_done_r <= 1'b0;
      captured_r   <= 1'b0;
    end else begin
      case (mode_s)
        MODE_SHIFT: begin
          captured_r <= 1'b0;
          if (cnt_r == CNT_LAST) begin
            cnt_r        <= {CNT_W{1'b0}};
            shift_done_r <= 1'b1;
          end else begin
            cnt_r        <= cnt_r + CNT_W'(1);
            shift_done_r <= 1'b0;
          end
        end
        MODE_LOAD: begin
          cnt_r        <= {CNT_W{1'b0}};
          shift_done_r <= 1'b0;
          captured_r   <= 1'b1;
        end
        MODE_HOLD: begin
          cnt_r        <= {CNT_W{1'b0}};
          shift_done_r <= 1'b0;
          captured_r   <= 1'b0;
        end
        default: begin
          cnt_r        <= {CNT_W{1'bx}};
          shift_done_r <= 1'bx;
          captured_r   <= 1'bx;
        end
      endcase
    end
  end

  assign SHIFT_DONE = shift_done_r;
  assign CAPTURED   = captured_r;

endmodule

// File: tb/tb_scan_reg_bank.sv
// Randomised and directed bench for scan_reg_bank against a chain-level
// reference model (16 bits / 2 chains), plus a 12 bits / 3 chains instance.
module tb_scan_reg_bank;

  localparam int          W  = 16;
  localparam int          C  = 2;
  localparam int          L  = 8;
  localparam logic [15:0] RV = 16'hA5A5;

  logic        CLK = 1'b0;
  logic        R   = 1'b0;
  logic        SE  = 1'b0;
  logic        E   = 1'b0;
  logic [15:0] D   = 16'h0000;
  logic [1:0]  SI  = 2'b00;
  logic [15:0] Q;
  logic [1:0]  SO;
  logic        SHIFT_DONE;
  logic        CAPTURED;

  logic        se_b = 1'b0;
  logic        e_b  = 1'b0;
  logic [11:0] d_b  = 12'h000;
  logic [2:0]  si_b = 3'b000;
  logic [11:0] q_b;
  logic [2:0]  so_b;
  logic        done_b;
  logic        capt_b;

  int n_pass   = 0;
  int n_checks = 0;

  logic [15:0] m_q;
  int          m_run;
  logic        m_done;
  logic        m_capt;

  scan_reg_bank #(.WIDTH(W), .CHAINS(C), .RESET_VAL(RV)) dut (
    .CLK(CLK), .R(R), .SE(SE), .E(E), .D(D), .SI(SI),
    .Q(Q), .SO(SO), .SHIFT_DONE(SHIFT_DONE), .CAPTURED(CAPTURED)
  );

  scan_reg_bank #(.WIDTH(12), .CHAINS(3)) dut_b (
    .CLK(CLK), .R(R), .SE(se_b), .E(e_b), .D(d_b), .SI(si_b),
    .Q(q_b), .SO(so_b), .SHIFT_DONE(done_b), .CAPTURED(capt_b)
  );

  always #5 CLK = ~CLK;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // each chain is an 8-bit shift register fed at its low end
  function automatic logic [15:0] model_shift(input logic [15:0] q, input logic [1:0] si);
    logic [15:0] r;
    r = 16'h0000;
    for (int c = 0; c < C; c++) begin
      int chain;
      chain = int'((q >> (c * L)) & 16'h00FF);
      chain = ((chain << 1) | int'(si[c])) & 32'h0000_00FF;
      r = r | 16'(chain << (c * L));
    end
    return r;
  endfunction

  task automatic model_reset();
    m_q = RV; m_run = 0; m_done = 1'b0; m_capt = 1'b0;
  endtask

  task automatic model_edge(input logic se, input logic e, input logic [15:0] d, input logic [1:0] si);
    if (se) begin
      m_q    = model_shift(m_q, si);
      m_run  = m_run + 1;
      m_done = ((m_run % L) == 0);
      m_capt = 1'b0;
    end else begin
      m_run  = 0;
      m_done = 1'b0;
      m_capt = e;
      if (e) m_q = d;
    end
  endtask

  task automatic check_all(input string tag);
    logic [1:0] eso;
    for (int c = 0; c < C; c++) eso[c] = m_q[c*L + L - 1];
    check_eq({tag, ".q"}, 32'(Q), 32'(m_q));
    check_eq({tag, ".so"}, 32'(SO), 32'(eso));
    check_eq({tag, ".done"}, 32'(SHIFT_DONE), 32'(m_done));
    check_eq({tag, ".capt"}, 32'(CAPTURED), 32'(m_capt));
  endtask

  task automatic cycle(input string tag, input logic se, input logic e,
                       input logic [15:0] d, input logic [1:0] si);
    SE = se; E = e; D = d; SI = si;
    @(posedge CLK);
    model_edge(se, e, d, si);
    #1;
    check_all(tag);
  endtask

  // asynchronous pulse placed between clock edges
  task automatic pulse_reset(input string tag);
    R = 1'b1;
    #2;
    model_reset();
    check_all(tag);
    R = 1'b0;
    #1;
  endtask

  initial begin
    model_reset();
    #2;
    R = 1'b1;
    #1;
    check_all("rst_async");
    check_eq("rst_so_const", 32'(SO), 32'h3);
    check_eq("rst_b_q", 32'(q_b), 32'h0);
    SE = 1'b1; SI = 2'b11;
    @(posedge CLK);
    #1;
    check_all("rst_held");
    SE = 1'b0; SI = 2'b00;
    R = 1'b0;

    // 12-bit / 3-chain instance: four all-ones shifts fill every chain
    for (int k = 1; k <= 4; k++) begin
      logic [11:0] exp_b;
      se_b = 1'b1; e_b = 1'b1; si_b = 3'b111; d_b = 12'($urandom);
      @(posedge CLK);
      model_edge(1'b0, 1'b0, 16'h0000, 2'b00);
      #1;
      exp_b = 12'h000;
      for (int c = 0; c < 3; c++) exp_b = exp_b | 12'(((1 << k) - 1) << (c * 4));
      check_eq($sformatf("sweep_q%0d", k), 32'(q_b), 32'(exp_b));
      check_eq($sformatf("sweep_done%0d", k), 32'(done_b), 32'(k == 4));
      check_eq($sformatf("sweep_capt%0d", k), 32'(capt_b), 32'h0);
    end
    se_b = 1'b0; e_b = 1'b0;
    @(posedge CLK);
    model_edge(1'b0, 1'b0, 16'h0000, 2'b00);
    #1;
    check_eq("sweep_after_done", 32'(done_b), 32'h0);
    check_eq("sweep_after_q", 32'(q_b), 32'hFFF);

    cycle("load", 1'b0, 1'b1, 16'h1234, 2'($urandom));
    check_eq("load_q_const", 32'(Q), 32'h1234);
    check_eq("load_capt_const", 32'(CAPTURED), 32'h1);
    cycle("hold", 1'b0, 1'b0, 16'hFFFF, 2'($urandom));
    check_eq("hold_q_const", 32'(Q), 32'h1234);

    for (int i = 0; i < 8; i++)
      cycle($sformatf("full%0d", i), 1'b1, 1'b1, 16'($urandom), (i % 2 == 0) ? 2'b01 : 2'b10);
    check_eq("full_q_const", 32'(Q), 32'h55AA);
    check_eq("full_done_const", 32'(SHIFT_DONE), 32'h1);
    cycle("full_post", 1'b0, 1'b0, 16'h0000, 2'b00);

    for (int i = 0; i < 5; i++) cycle($sformatf("intA%0d", i), 1'b1, 1'b0, 16'h0000, 2'($urandom));
    cycle("intA_gap", 1'b0, 1'b0, 16'h0000, 2'b00);
    for (int i = 0; i < 8; i++) cycle($sformatf("intA%0d", i + 6), 1'b1, 1'b0, 16'h0000, 2'($urandom));
    check_eq("intA_done_const", 32'(SHIFT_DONE), 32'h1);

    for (int i = 0; i < 5; i++) cycle($sformatf("intB%0d", i), 1'b1, 1'b0, 16'h0000, 2'($urandom));
    pulse_reset("intB_rst");
    for (int i = 0; i < 8; i++) cycle($sformatf("intB%0d", i + 5), 1'b1, 1'b0, 16'h0000, 2'($urandom));
    check_eq("intB_done_const", 32'(SHIFT_DONE), 32'h1);

    cycle("thru_load", 1'b0, 1'b1, 16'h8001, 2'b00);
    SE = 1'b1; SI = 2'b00;
    #1;
    check_eq("thru_so0", 32'(SO), 32'h2);
    for (int i = 1; i <= 8; i++) begin
      cycle($sformatf("thru%0d", i), 1'b1, 1'b0, 16'h0000, 2'b00);
      if (i == 7) check_eq("thru_so7", 32'(SO), 32'h1);
    end
    check_eq("thru_q8", 32'(Q), 32'h0);

    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 39) == 0) pulse_reset($sformatf("rnd_rst%0d", i));
      cycle($sformatf("rnd%0d", i), $urandom_range(0, 3) != 0, 1'($urandom),
            16'($urandom), 2'($urandom));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
